// File: rtl/count_seq_checker.sv
//------------------------------------------------------------------------------
// count_seq_checker
// Receive-side monitor for a free-running up-counter stream. Predicts the
// next sample (count_in + 1, modulo 2^WIDTH), acquires lock after LOCK_CNT
// consecutive correct samples, then flags/counts sequence errors and wraps.
// Optional feature macro: COUNT_CHK_RESET_TOLERANT_EN
//   When defined, a locked sample of zero against a non-zero prediction is
//   accepted as a legitimate counter reset instead of an error.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module count_seq_checker #(
   parameter int WIDTH    = 8,
   parameter int LOCK_CNT = 4,   // legal range 1..15
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] count_in,
   output logic             locked,
   output logic             err_pulse,
   output logic             wrap_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACQUIRE = 2'd1;
   localparam logic [1:0] S_LOCKED  = 2'd2;

   // Run counter is 4 bits wide since LOCK_CNT never exceeds 15.
   localparam logic [3:0] LOCK_TGT  = 4'(LOCK_CNT);

   logic [1:0]       state_q, state_d;
   logic [3:0]       run_q, run_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [ERR_W-1:0] errc_q, errc_d;
   logic             lock_q, lock_d;
   logic             errp_q, errp_d;
   logic             wrapp_q, wrapp_d;

   logic [WIDTH-1:0] pred_next;
   logic             hit;

   assign pred_next = count_in + {{(WIDTH-1){1'b0}}, 1'b1};
   assign hit       = (count_in == exp_q);

   // Next-state logic: prediction, lock acquisition and error accounting.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      exp_d   = exp_q;
      errc_d  = errc_q;
      lock_d  = lock_q;
      errp_d  = 1'b0;
      wrapp_d = 1'b0;

      if (sample_en) begin
         // Every sample resyncs the prediction to the observed value.
         exp_d = pred_next;
         case (state_q)
            S_IDLE: begin
               run_d = 4'd1;
               if (LOCK_TGT == 4'd1) begin
                  state_d = S_LOCKED;
                  lock_d  = 1'b1;
               end else begin
                  state_d = S_ACQUIRE;
               end
            end
            S_ACQUIRE: begin
               if (hit) begin
                  run_d = run_q + 4'd1;
                  if ((run_q + 4'd1) == LOCK_TGT) begin
                     state_d = S_LOCKED;
                     lock_d  = 1'b1;
                  end
               end else begin
                  run_d = 4'd1;
               end
            end
            S_LOCKED: begin
               if (hit) begin
                  if (count_in == '0) begin
                     wrapp_d = 1'b1;
                  end
               end
`ifdef COUNT_CHK_RESET_TOLERANT_EN
               else if (count_in == '0) begin
                  // Counter restarted from zero: stay locked, prediction is
                  // already 1 from pred_next, no error raised.
                  lock_d = 1'b1;
               end
`endif
               else begin
                  errp_d  = 1'b1;
                  lock_d  = 1'b0;
                  state_d = S_ACQUIRE;
                  run_d   = 4'd1;
                  if (errc_q != {ERR_W{1'b1}}) begin
                     errc_d = errc_q + {{(ERR_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               lock_d  = 1'b0;
               run_d   = 4'd0;
            end
         endcase
      end
   end

   // State and output registers; reset clears everything including pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         run_q   <= 4'd0;
         exp_q   <= '0;
         errc_q  <= '0;
         lock_q  <= 1'b0;
         errp_q  <= 1'b0;
         wrapp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         exp_q   <= exp_d;
         errc_q  <= errc_d;
         lock_q  <= lock_d;
         errp_q  <= errp_d;
         wrapp_q <= wrapp_d;
      end
   end

   assign locked     = lock_q;
   assign err_pulse  = errp_q;
   assign wrap_pulse = wrapp_q;
   assign err_count  = errc_q;
   assign expected   = exp_q;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_checker.sv
//------------------------------------------------------------------------------
// tb_count_seq_checker
// Directed bench for count_seq_checker. The error counter is narrowed to
// 8 bits so that saturation can be reached through real lock/mismatch cycles.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_count_seq_checker;

   localparam int WIDTH    = 8;
   localparam int LOCK_CNT = 4;
   localparam int ERR_W    = 8;

   logic             clk;
   logic             reset;
   logic             sample_en;
   logic [WIDTH-1:0] count_in;
   logic             locked;
   logic             err_pulse;
   logic             wrap_pulse;
   logic [ERR_W-1:0] err_count;
   logic [WIDTH-1:0] expected;

   int checks;
   int failures;
   int err_model;

   count_seq_checker #(
      .WIDTH    (WIDTH),
      .LOCK_CNT (LOCK_CNT),
      .ERR_W    (ERR_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sample_en  (sample_en),
      .count_in   (count_in),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .wrap_pulse (wrap_pulse),
      .err_count  (err_count),
      .expected   (expected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one sample; returns 1 time unit after the capturing edge.
   task automatic sample(input logic [7:0] v);
      sample_en = 1'b1;
      count_in  = v;
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n, input logic [7:0] junk);
      sample_en = 1'b0;
      count_in  = junk;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] m;
      checks    = 0;
      failures  = 0;
      err_model = 0;
      reset     = 1'b1;
      sample_en = 1'b0;
      count_in  = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_errp", 32'(err_pulse), 32'd0);
      check("rst_wrap", 32'(wrap_pulse), 32'd0);
      check("rst_errc", 32'(err_count), 32'd0);
      check("rst_exp", 32'(expected), 32'd0);
      reset = 1'b0;
      gap(1, 8'h00);

      // Acquisition: 0x10..0x13
      sample(8'h10);
      sample(8'h11);
      sample(8'h12);
      check("acq_not_locked", 32'(locked), 32'd0);
      check("acq_exp", 32'(expected), 32'h13);
      sample(8'h13);
      check("lock_rise", 32'(locked), 32'd1);
      check("lock_exp", 32'(expected), 32'h14);
      check("lock_errc", 32'(err_count), 32'd0);

      // Run up to the wrap
      for (int i = 8'h14; i <= 8'hFD; i++) sample(8'(i));
      check("pre_wrap_exp", 32'(expected), 32'hFE);
      check("pre_wrap_locked", 32'(locked), 32'd1);
      sample(8'hFE);
      check("fe_wrap", 32'(wrap_pulse), 32'd0);
      sample(8'hFF);
      check("ff_wrap", 32'(wrap_pulse), 32'd0);
      check("ff_exp", 32'(expected), 32'h00);
      sample(8'h00);
      check("wrap_pulse", 32'(wrap_pulse), 32'd1);
      check("wrap_errp", 32'(err_pulse), 32'd0);
      check("wrap_exp", 32'(expected), 32'h01);
      sample(8'h01);
      check("wrap_one_cycle", 32'(wrap_pulse), 32'd0);

      // Mismatch while locked, then relock
      for (int i = 8'h02; i <= 8'h1F; i++) sample(8'(i));
      check("pre_err_exp", 32'(expected), 32'h20);
      sample(8'h25);
      err_model++;
      check("mm_errp", 32'(err_pulse), 32'd1);
      check("mm_wrap", 32'(wrap_pulse), 32'd0);
      check("mm_errc", 32'(err_count), 32'(err_model));
      check("mm_locked", 32'(locked), 32'd0);
      check("mm_exp", 32'(expected), 32'h26);
      sample(8'h26);
      check("mm_errp_clear", 32'(err_pulse), 32'd0);
      check("relock_26", 32'(locked), 32'd0);
      sample(8'h27);
      check("relock_27", 32'(locked), 32'd0);
      sample(8'h28);
      check("relock_28", 32'(locked), 32'd1);
      check("relock_exp", 32'(expected), 32'h29);

      // Idle gaps, including garbage on count_in
      gap(10, 8'h29);
      check("gap_locked", 32'(locked), 32'd1);
      check("gap_exp", 32'(expected), 32'h29);
      sample(8'h29);
      check("gap_errp", 32'(err_pulse), 32'd0);
      check("gap_locked2", 32'(locked), 32'd1);
      gap(3, 8'h77);
      check("junk_exp", 32'(expected), 32'h2A);
      check("junk_errc", 32'(err_count), 32'(err_model));
      sample(8'h2A);
      check("junk_errp", 32'(err_pulse), 32'd0);

      // Constant count_in is a mismatch every sample
      sample(8'h2B);
      sample(8'h2B);
      err_model++;
      check("hold_errp", 32'(err_pulse), 32'd1);
      check("hold_errc", 32'(err_count), 32'(err_model));
      check("hold_exp", 32'(expected), 32'h2C);
      sample(8'h2B);
      check("hold_acq_errp", 32'(err_pulse), 32'd0);
      check("hold_acq_errc", 32'(err_count), 32'(err_model));

      // Lock with expected=0x40, then sample 0x00
      sample(8'h3C);
      sample(8'h3D);
      sample(8'h3E);
      sample(8'h3F);
      check("l40_locked", 32'(locked), 32'd1);
      check("l40_exp", 32'(expected), 32'h40);
      sample(8'h00);
`ifdef COUNT_CHK_RESET_TOLERANT_EN
      check("zero_errp", 32'(err_pulse), 32'd0);
      check("zero_locked", 32'(locked), 32'd1);
`else
      err_model++;
      check("zero_errp", 32'(err_pulse), 32'd1);
      check("zero_locked", 32'(locked), 32'd0);
`endif
      check("zero_wrap", 32'(wrap_pulse), 32'd0);
      check("zero_exp", 32'(expected), 32'h01);
      check("zero_errc", 32'(err_count), 32'(err_model));
      sample(8'h01);
      sample(8'h02);
      sample(8'h03);
      check("zero_relock", 32'(locked), 32'd1);

      // Saturation: mismatch + relock until all-ones minus one
      v = 8'h04;
      while (err_model < 254) begin
         m = (v == 8'h80) ? 8'h81 : (v ^ 8'h80);
         sample(m);
         sample(m + 8'd1);
         sample(m + 8'd2);
         sample(m + 8'd3);
         v = m + 8'd4;
         err_model++;
      end
      check("sat_pre_errc", 32'(err_count), 32'd254);
      check("sat_pre_locked", 32'(locked), 32'd1);
      for (int k = 0; k < 2; k++) begin
         m = (v == 8'h80) ? 8'h81 : (v ^ 8'h80);
         sample(m);
         check("sat_errp", 32'(err_pulse), 32'd1);
         check("sat_errc", 32'(err_count), 32'hFF);
         sample(m + 8'd1);
         sample(m + 8'd2);
         sample(m + 8'd3);
         v = m + 8'd4;
      end
      check("sat_relock", 32'(locked), 32'd1);

      // Async reset mid-sequence with a pending error pulse
      sample(v ^ 8'h55);
      check("pre_rst_errp", 32'(err_pulse), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_locked", 32'(locked), 32'd0);
      check("arst_errp", 32'(err_pulse), 32'd0);
      check("arst_wrap", 32'(wrap_pulse), 32'd0);
      check("arst_errc", 32'(err_count), 32'd0);
      check("arst_exp", 32'(expected), 32'd0);
      sample_en = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      gap(1, 8'h00);

      // Fresh acquisition after reset: no partial lock carried over
      sample(8'h50);
      check("post_rst_locked", 32'(locked), 32'd0);
      check("post_rst_exp", 32'(expected), 32'h51);
      sample(8'h51);
      sample(8'h52);
      check("post_rst_acq", 32'(locked), 32'd0);
      sample(8'h53);
      check("post_rst_lock", 32'(locked), 32'd1);
      gap(2, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
